// File: rtl/serial_receive.sv
// ---------------------------------------------------------------------------
// serial_receive
//
// Receiving end of the one-bit-per-clock serial link. A frame is WIDTH data
// slots (MSB first) followed by one separator slot that must read 0. Frames
// run back to back with no idle slots in between. Each good word lands in a
// holding register and is offered to the consumer with a valid/ack handshake.
//
// Ports:
//   clk               system clock, one bit slot per rising edge
//   rst               synchronous reset, active-low
//   rxd               serial data line (idles 1)
//   connection_status link-up qualifier; first cycle at 1 is data slot 0
//   word_out          last good received word
//   word_valid        word_out holds an unconsumed word
//   word_ack          consumer takes word_out when word_valid & word_ack
//   frame_error       one-cycle pulse: separator slot was 1, frame dropped
//   overrun           one-cycle pulse: good frame arrived while the holding
//                     register was full and not acked, new frame dropped
//   busy              1 while a frame is in progress (DATA or SEP)
// ---------------------------------------------------------------------------
module serial_receive #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    input  logic             connection_status,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ack,
    output logic             frame_error,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_SEP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH:0]     w_shift_ext;
    logic               w_shift;
    logic               w_good;
    logic               w_bad;

    // Widened shift keeps the expression legal for WIDTH=1.
    assign w_shift_ext = {r_shreg, rxd};

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state / slot decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;

        if (!connection_status) begin
            // Link down: abandon any partial frame silently.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DATA: begin
                    // IDLE with link up is data slot 0, same as DATA with
                    // counter 0 (the slot after a separator).
                    w_shift   = 1'b1;
                    w_cnt_nxt = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
                    w_state_nxt = (w_cnt_nxt == CNT_W'(WIDTH)) ? S_SEP : S_DATA;
                end
                S_SEP: begin
                    w_good      = ~rxd;
                    w_bad       = rxd;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Shift register, holding register, handshake and status pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shreg     <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= w_bad;
            overrun     <= 1'b0;

            if (w_shift) begin
                r_shreg <= w_shift_ext[WIDTH-1:0];
            end

            if (w_good) begin
                // A same-cycle ack frees the register for the new word.
                if (!word_valid || word_ack) begin
                    word_out   <= r_shreg;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ack) begin
                word_valid <= 1'b0;
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_receive.sv
// ---------------------------------------------------------------------------
// tb_serial_receive
//
// Drives serial frames on the falling edge and samples DUT outputs on the
// falling edge before new inputs are applied. Good frames that the consumer
// should eventually receive are pushed to a scoreboard queue when their
// separator slot is driven and popped when the bench acks the word.
// ---------------------------------------------------------------------------
module tb_serial_receive;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         rxd;
    logic         connection_status;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ack;
    logic         frame_error;
    logic         overrun;
    logic         busy;

    int n_cmp;
    int n_bad;
    int ov_cnt;
    int fe_cnt;
    logic [W-1:0] sb[$];

    serial_receive #(.WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .rxd               (rxd),
        .connection_status (connection_status),
        .word_out          (word_out),
        .word_valid        (word_valid),
        .word_ack          (word_ack),
        .frame_error       (frame_error),
        .overrun           (overrun),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun)     ov_cnt++;
        if (frame_error) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer takes the current word: compare with scoreboard head and ack.
    task automatic take_word(input string tag);
        logic [W-1:0] exp;
        chk({tag, "_valid"}, word_valid, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_word"}, word_out, exp);
        end
        word_ack = 1'b1;
    endtask

    task automatic slot(input logic b, input logic ack);
        @(negedge clk);
        if (ack) take_word("ack_in_frame");
        else     word_ack = 1'b0;
        rxd               = b;
        connection_status = 1'b1;
    endtask

    task automatic frame(input logic [W-1:0] d, input logic sep, input logic push, input int ack_slot);
        for (int i = 0; i < W; i++) slot(d[W-1-i], ack_slot == i);
        slot(sep, ack_slot == W);
        if (push) sb.push_back(d);
    endtask

    task automatic go_idle();
        connection_status = 1'b0;
        rxd               = 1'b1;
    endtask

    int fe0;
    int ov0;

    initial begin
        n_cmp = 0; n_bad = 0; ov_cnt = 0; fe_cnt = 0;
        rst = 1'b0; rxd = 1'b1; connection_status = 1'b0; word_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_word_out", word_out, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fe_ov", {frame_error, overrun}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single frame A5: valid exactly the cycle after the separator
        frame(8'hA5, 1'b0, 1'b1, -1);
        @(negedge clk);
        chk("a5_valid", word_valid, 1);
        chk("a5_word", word_out, 8'hA5);
        chk("a5_fe", frame_error, 0);
        take_word("a5");
        go_idle();
        @(negedge clk);
        word_ack = 1'b0;
        chk("a5_valid_cleared", word_valid, 0);
        chk("a5_word_hold", word_out, 8'hA5);

        // Back-to-back 3C, C3 with ack in the cycle valid first rises
        ov0 = ov_cnt;
        frame(8'h3C, 1'b0, 1'b1, -1);
        frame(8'hC3, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("c3_valid", word_valid, 1);
        take_word("c3");
        go_idle();
        @(negedge clk);
        word_ack = 1'b0;
        chk("b2b_no_overrun", 32'(ov_cnt - ov0), 0);

        // Overrun: 11 then 22 with no ack
        ov0 = ov_cnt;
        frame(8'h11, 1'b0, 1'b1, -1);
        frame(8'h22, 1'b0, 1'b0, -1);
        @(negedge clk);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_word_kept", word_out, 8'h11);
        chk("ovr_valid", word_valid, 1);
        go_idle();
        @(negedge clk);
        chk("ovr_pulse_end", overrun, 0);
        chk("ovr_count", 32'(ov_cnt - ov0), 1);
        take_word("ovr");
        @(negedge clk);
        word_ack = 1'b0;

        // Frame error on FF, then good 5A
        fe0 = fe_cnt;
        frame(8'hFF, 1'b1, 1'b0, -1);
        @(negedge clk);
        chk("fe_pulse", frame_error, 1);
        chk("fe_valid", word_valid, 0);
        go_idle();
        @(negedge clk);
        chk("fe_pulse_end", frame_error, 0);
        chk("fe_count", 32'(fe_cnt - fe0), 1);
        frame(8'h5A, 1'b0, 1'b1, -1);
        @(negedge clk);
        chk("5a_fe", frame_error, 0);
        take_word("5a");
        go_idle();
        @(negedge clk);
        word_ack = 1'b0;

        // Link drop after 4 data bits, then full frame 81
        fe0 = fe_cnt;
        for (int i = 0; i < 4; i++) slot(1'b1, 1'b0);
        @(negedge clk);
        chk("drop_busy_mid", busy, 1);
        go_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drop_busy_low", busy, 0);
        end
        frame(8'h81, 1'b0, 1'b1, -1);
        @(negedge clk);
        chk("81_word", word_out, 8'h81);
        chk("drop_no_fe", 32'(fe_cnt - fe0), 0);
        take_word("81");
        go_idle();
        @(negedge clk);
        word_ack = 1'b0;

        // Reset mid-frame with a pending word, then frame 0F
        frame(8'h77, 1'b0, 1'b0, -1);
        for (int i = 0; i < 3; i++) slot(1'b0, 1'b0);
        chk("pre_rst_valid", word_valid, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_word", word_out, 0);
        chk("mid_rst_valid", word_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fe_ov", {frame_error, overrun}, 0);
        rst = 1'b1;
        go_idle();
        @(negedge clk);
        frame(8'h0F, 1'b0, 1'b1, -1);
        @(negedge clk);
        chk("0f_word", word_out, 8'h0F);
        take_word("0f");
        go_idle();
        @(negedge clk);
        word_ack = 1'b0;
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_receive.md
Name: serial_receive

Overview:
- Receiving end of the team's one-bit-per-clock serial link.
- Deserialises MSB-first data frames from `rxd` and checks the trailing separator slot.
- Presents each good word on a holding register with a valid/ack handshake.
- Sits at the link input and feeds the consumer logic (e.g. a FIFO or decoder).

Parameters:
- WIDTH, 8, data bits per frame; a frame is WIDTH+1 slots (WIDTH data, MSB first, then one separator slot).

Ports:
- clk  input  1  system clock; one bit slot per rising edge
- rst  input  1  reset, synchronous, active-low (asserted when 0)
- rxd  input  1  serial data line; idles 1
- connection_status  input  1  link-up qualifier, delayed one clk from the transmitter's copy, so the cycle it first reads 1 is data slot 0 of the first frame
- word_out  output  WIDTH  last good received word
- word_valid  output  1  word_out holds an unconsumed word
- word_ack  input  1  consumer takes word_out when word_valid=1 and word_ack=1
- frame_error  output  1  one-cycle pulse: separator slot was 1, frame discarded
- overrun  output  1  one-cycle pulse: good frame arrived while holding register full and not acked, new frame discarded
- busy  output  1  1 while a frame is in progress (DATA or SEP state)

Behaviour:
- All state is updated on posedge clk.
- Reset (rst=0 at a clock edge), which overrides everything:
  - state=IDLE, slot counter=0, shift register=0.
  - word_out=0, word_valid=0, frame_error=0, overrun=0, busy=0.
  - Reset mid-frame discards the partial frame; a pending word_valid is cleared.
- States and transitions:
  - IDLE, connection_status=1: sample rxd as data bit WIDTH-1 (slot 0), counter=1, go to DATA.
  - DATA, each cycle with connection_status=1: shift rxd into the LSB (shreg = {shreg[WIDTH-2:0], rxd}), counter+1. After slot WIDTH-1 is captured, go to SEP.
  - SEP, connection_status=1: sample rxd as the separator.
    - rxd=0: good frame.
    - rxd=1: pulse frame_error next cycle and discard the frame.
    - Either way counter=0 and go straight to DATA. The next cycle is slot 0 of the next frame; there are no idle slots between frames.
  - Any state, connection_status=0: go to IDLE, counter=0, partial frame discarded, no error pulse.
- Counter is ceil(log2(WIDTH+1)) bits and never exceeds WIDTH.
- Word delivery on a good frame:
  - If word_valid=0, or word_valid=1 with word_ack=1 in the same cycle: word_out <= assembled word, word_valid <= 1.
  - Latency: word_valid is seen 1 in the cycle after the separator slot.
- Handshake:
  - word_ack with word_valid=1 and no simultaneous good frame: word_valid <= 0; word_out holds its value.
  - word_ack while word_valid=0 is ignored.
  - Simultaneous ack and good frame: the new word replaces the old and word_valid stays 1; no overrun.
- Overrun: good frame while word_valid=1 and word_ack=0.
  - overrun pulses 1 for one cycle.
  - word_out and word_valid are unchanged; the old word is kept.
- frame_error and overrun are registered single-cycle pulses and are mutually exclusive per frame.
- busy=1 in DATA and SEP, 0 in IDLE.

Test Plan:
- Reset, then connection_status=1 with rxd = 1,0,1,0,0,1,0,1 then 0 -> word_out=8'hA5, word_valid=1 exactly one cycle after the separator slot; frame_error=0.
- Back-to-back frames 8'h3C then 8'hC3 (18 consecutive slots), with word_ack pulsed in the cycle word_valid first rises -> consumer receives 3C then C3; no overrun.
- Two good frames 8'h11 then 8'h22 with word_ack held 0 -> word_out stays 11, word_valid=1, overrun pulses once one cycle after the second separator.
- Frame 8'hFF with separator slot rxd=1 -> frame_error one-cycle pulse; word_valid stays 0; the following frame 8'h5A is received correctly.
- connection_status dropped to 0 after 4 data bits, then restored with a full frame 8'h81 -> partial frame discarded with no error pulse; busy=0 while dropped; word_out=8'h81.
- rst=0 for one cycle mid-frame with word_valid=1 -> all outputs 0 the next cycle; the next complete frame 8'h0F is received normally.
